// File: rtl/display_scheduler_if.sv
// Byte-stream link from the display scheduler to a character sink.
interface display_scheduler_if;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready;

    modport master (output tx_data, output tx_valid, input tx_ready);
    modport slave  (input tx_data, input tx_valid, output tx_ready);
endinterface

// File: rtl/display_scheduler.sv
// Display scheduler: on a timer tick or an explicit request, snapshots the
// time/distance/speed digits and streams a fixed 20-character text frame
// "T=m:ss D=dddd S=ss\r\n" over a valid/ready byte link.
module display_scheduler #(
    parameter int unsigned REFRESH_CYCLES = 100000000
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       frame_req,
    input  logic                       clr_overrun,
    input  logic [6:0]                 mins,
    input  logic [6:0]                 tens,
    input  logic [6:0]                 ones,
    input  logic [6:0]                 distThousands,
    input  logic [6:0]                 distHundreds,
    input  logic [6:0]                 distTens,
    input  logic [6:0]                 distOnes,
    input  logic [6:0]                 speedTens,
    input  logic [6:0]                 speedOnes,
    display_scheduler_if.master        tx,
    output logic                       busy,
    output logic                       frame_done,
    output logic                       overrun
);
    typedef enum logic [1:0] {IDLE = 2'd0, LOAD = 2'd1, SEND = 2'd2, DONE = 2'd3} state_t;

    localparam logic [31:0] TIMER_LAST = (REFRESH_CYCLES == 0) ? 32'd0 : 32'(REFRESH_CYCLES - 1);
    localparam logic [4:0]  LAST_IDX   = 5'd19;
    localparam logic [6:0]  ASCII_ZERO = 7'h30;

    state_t          state_q, state_d;
    logic [31:0]     timer_q, timer_d;
    logic            tick, req, accept, tx_valid;
    logic            pending_q, pending_d;
    logic            overrun_q, overrun_d;
    logic [4:0]      idx_q, idx_d, idx_nxt;
    logic [7:0]      tx_data_q, tx_data_d, next_char;
    // Snapshot order: 0 mins, 1 tens, 2 ones, 3..6 distance (thousands..ones), 7..8 speed.
    logic [8:0][6:0] snap_q, snap_d;

    // Non-digit codes are shown as '?' so a bad source never corrupts the frame layout.
    function automatic logic [7:0] digit_char(input logic [6:0] d);
        if (d >= 7'h30 && d <= 7'h39) return {1'b0, d};
        else                          return 8'h3F;
    endfunction

    assign accept      = tx_valid & tx.tx_ready;
    assign tx.tx_valid = tx_valid;
    assign tx.tx_data  = tx_data_q;
    assign overrun     = overrun_q;

    // Free-running refresh timer; REFRESH_CYCLES of 0 leaves it parked with no ticks.
    always_comb begin
        tick    = 1'b0;
        timer_d = timer_q;
        if (REFRESH_CYCLES != 0) begin
            if (timer_q == TIMER_LAST) begin
                tick    = 1'b1;
                timer_d = 32'd0;
            end else begin
                timer_d = timer_q + 32'd1;
            end
        end
    end

    // Single-deep request latch; a request in LOAD refills the slot being consumed, so it is not lost.
    always_comb begin
        req       = tick | frame_req;
        pending_d = pending_q;
        if (req)                  pending_d = 1'b1;
        else if (state_q == LOAD) pending_d = 1'b0;
        overrun_d = overrun_q;
        if (req && pending_q && (state_q != LOAD)) overrun_d = 1'b1;
        else if (clr_overrun)                      overrun_d = 1'b0;
    end

    // Character following the current one in the frame.
    always_comb begin
        idx_nxt   = idx_q + 5'd1;
        next_char = 8'h00;
        case (idx_nxt)
            5'd0:  next_char = "T";
            5'd1:  next_char = "=";
            5'd2:  next_char = digit_char(snap_q[0]);
            5'd3:  next_char = ":";
            5'd4:  next_char = digit_char(snap_q[1]);
            5'd5:  next_char = digit_char(snap_q[2]);
            5'd6:  next_char = " ";
            5'd7:  next_char = "D";
            5'd8:  next_char = "=";
            5'd9:  next_char = digit_char(snap_q[3]);
            5'd10: next_char = digit_char(snap_q[4]);
            5'd11: next_char = digit_char(snap_q[5]);
            5'd12: next_char = digit_char(snap_q[6]);
            5'd13: next_char = " ";
            5'd14: next_char = "S";
            5'd15: next_char = "=";
            5'd16: next_char = digit_char(snap_q[7]);
            5'd17: next_char = digit_char(snap_q[8]);
            5'd18: next_char = 8'h0D;
            5'd19: next_char = 8'h0A;
            default: next_char = 8'h00;
        endcase
    end

    // Frame datapath: snapshot and restart in LOAD, advance one character per accepted byte.
    always_comb begin
        idx_d     = idx_q;
        tx_data_d = tx_data_q;
        snap_d    = snap_q;
        case (state_q)
            LOAD: begin
                idx_d     = 5'd0;
                tx_data_d = "T";
                snap_d    = {speedOnes, speedTens, distOnes, distTens,
                             distHundreds, distThousands, ones, tens, mins};
            end
            SEND: begin
                if (accept && (idx_q != LAST_IDX)) begin
                    idx_d     = idx_nxt;
                    tx_data_d = next_char;
                end
            end
            default: ;
        endcase
    end

    // FSM state register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state_q <= IDLE;
        else        state_q <= state_d;
    end

    // FSM next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: if (pending_q) state_d = LOAD;
            LOAD: state_d = SEND;
            SEND: if (accept && (idx_q == LAST_IDX)) state_d = DONE;
            DONE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // FSM outputs decoded from the state register.
    always_comb begin
        busy       = (state_q != IDLE);
        tx_valid   = (state_q == SEND);
        frame_done = (state_q == DONE);
    end

    // Timer, request flags and frame datapath registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            timer_q   <= 32'd0;
            pending_q <= 1'b0;
            overrun_q <= 1'b0;
            idx_q     <= 5'd0;
            tx_data_q <= 8'h00;
            snap_q    <= {9{ASCII_ZERO}};
        end else begin
            timer_q   <= timer_d;
            pending_q <= pending_d;
            overrun_q <= overrun_d;
            idx_q     <= idx_d;
            tx_data_q <= tx_data_d;
            snap_q    <= snap_d;
        end
    end
endmodule
